// File: rtl/store_write_buffer.sv
// Purpose : posted-write FIFO between the store path and the BCU write port, with line-hazard flag and drain-on-shutdown.
// Latency : a store into an empty idle buffer is presented to the BCU (wb_request_n=0) one clock after it is accepted.
// Backpressure: st_stall while full or shutting down (registered state only; a same-cycle pop does not free a slot).
//
// Ports:
//   sys_clk, iResetn                    clock, asynchronous active-low reset
//   st_request_n/st_address/st_data/st_size, st_stall
//                                       store input (active-low pulse), stall back to the producer
//   wb_request_n/wb_address/wb_data/wb_size, wb_accept_n
//                                       BCU write request (registered) and its one-clock accept
//   rd_check_address, rd_hazard         16-byte-line hazard check for a pending miss read
//   start_shutdown, finished_shutdown   drain request pulse, sticky drain-complete flag
//   wb_empty                            buffer holds no entries
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              sys_clk,
    input  logic              iResetn,
    input  logic              st_request_n,
    input  logic [ADDR_W-1:0] st_address,
    input  logic [DATA_W-1:0] st_data,
    input  logic              st_size,
    output logic              st_stall,
    output logic              wb_request_n,
    output logic [ADDR_W-1:0] wb_address,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_size,
    input  logic              wb_accept_n,
    input  logic [ADDR_W-1:0] rd_check_address,
    output logic              rd_hazard,
    input  logic              start_shutdown,
    output logic              finished_shutdown,
    output logic              wb_empty
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              size;
    } entry_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [1:0]       state;
    logic             gap_cnt;
    logic             shutting;

    logic             push;
    logic             pop;

    assign st_stall = (count == FULL_CNT) | shutting;
    assign wb_empty = (count == '0);
    assign push     = ~st_request_n & ~st_stall;
    assign pop      = (state == S_REQ) & ~wb_accept_n;

    // Storage and write pointer
    always_ff @(posedge sys_clk or negedge iResetn) begin
        if (!iResetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            tail <= '0;
        end else if (push) begin
            mem[tail] <= '{addr: st_address, data: st_data, size: st_size};
            tail      <= tail + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge sys_clk or negedge iResetn) begin
        if (!iResetn) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Drain FSM; the head entry is popped only when its request is accepted
    always_ff @(posedge sys_clk or negedge iResetn) begin
        if (!iResetn) begin
            state        <= S_IDLE;
            gap_cnt      <= 1'b0;
            head         <= '0;
            wb_request_n <= 1'b1;
            wb_address   <= '0;
            wb_data      <= '0;
            wb_size      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        wb_address   <= mem[head].addr;
                        wb_data      <= mem[head].data;
                        wb_size      <= mem[head].size;
                        wb_request_n <= 1'b0;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!wb_accept_n) begin
                        head         <= head + 1'b1;
                        wb_request_n <= 1'b1;
                        gap_cnt      <= 1'b0;
                        state        <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Two idle clocks let the BCU settle before the next request
                    if (gap_cnt) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    wb_request_n <= 1'b1;
                end
            endcase
        end
    end

    // Shutdown: the flag is sticky until reset; a repeated pulse changes nothing
    always_ff @(posedge sys_clk or negedge iResetn) begin
        if (!iResetn) begin
            shutting          <= 1'b0;
            finished_shutdown <= 1'b0;
        end else begin
            if (start_shutdown) begin
                shutting <= 1'b1;
            end
            if (shutting && (count == '0) && (state == S_IDLE)) begin
                finished_shutdown <= 1'b1;
            end
        end
    end

    // Hazard compare against occupied slots only; slot i is occupied when its
    // distance from head (mod DEPTH) is below count. The entry under request
    // stays occupied until its pop.
    logic [PTR_W-1:0] offs;
    always_comb begin
        rd_hazard = 1'b0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - head;
            if (({1'b0, offs} < count) &&
                (mem[i].addr[ADDR_W-1:4] == rd_check_address[ADDR_W-1:4])) begin
                rd_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Purpose : directed self-checking bench for store_write_buffer with an in-order scoreboard of expected BCU writes.
// Latency : inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench only queues an expected write when the store should be accepted.
module tb_store_write_buffer;

    logic        sys_clk;
    logic        iResetn;
    logic        st_request_n;
    logic [31:0] st_address;
    logic [31:0] st_data;
    logic        st_size;
    logic        st_stall;
    logic        wb_request_n;
    logic [31:0] wb_address;
    logic [31:0] wb_data;
    logic        wb_size;
    logic        wb_accept_n;
    logic [31:0] rd_check_address;
    logic        rd_hazard;
    logic        start_shutdown;
    logic        finished_shutdown;
    logic        wb_empty;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    store_write_buffer #(.DEPTH(4), .PTR_W(2), .ADDR_W(32), .DATA_W(32)) dut (
        .sys_clk           (sys_clk),
        .iResetn           (iResetn),
        .st_request_n      (st_request_n),
        .st_address        (st_address),
        .st_data           (st_data),
        .st_size           (st_size),
        .st_stall          (st_stall),
        .wb_request_n      (wb_request_n),
        .wb_address        (wb_address),
        .wb_data           (wb_data),
        .wb_size           (wb_size),
        .wb_accept_n       (wb_accept_n),
        .rd_check_address  (rd_check_address),
        .rd_hazard         (rd_hazard),
        .start_shutdown    (start_shutdown),
        .finished_shutdown (finished_shutdown),
        .wb_empty          (wb_empty)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic s, input logic push);
        st_request_n = 1'b0;
        st_address   = a;
        st_data      = d;
        st_size      = s;
        if (push) sb.push_back('{a: a, d: d, s: s});
        tick();
        st_request_n = 1'b1;
    endtask

    // Wait (bounded) for a request, compare it with the scoreboard head, then
    // accept it, optionally with a store in the same clock.
    task automatic accept_head(input string tag, input logic do_st, input logic [31:0] a,
                               input logic [31:0] d, input logic s, input logic push);
        int   k;
        exp_t e;
        k = 0;
        while (wb_request_n !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        check({tag, " req"}, 64'(wb_request_n), 64'(1'b0));
        check({tag, " sb_nonempty"}, 64'(sb.size() != 0), 64'(1'b1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, " addr"}, 64'(wb_address), 64'(e.a));
            check({tag, " data"}, 64'(wb_data), 64'(e.d));
            check({tag, " size"}, 64'(wb_size), 64'(e.s));
        end
        wb_accept_n = 1'b0;
        if (do_st) begin
            st_request_n = 1'b0;
            st_address   = a;
            st_data      = d;
            st_size      = s;
            if (push) sb.push_back('{a: a, d: d, s: s});
        end
        tick();
        wb_accept_n  = 1'b1;
        st_request_n = 1'b1;
    endtask

    // Nothing further may be presented once the scoreboard is drained
    task automatic expect_idle(input string tag);
        repeat (6) tick();
        check({tag, " idle_req"}, 64'(wb_request_n), 64'(1'b1));
        check({tag, " idle_empty"}, 64'(wb_empty), 64'(1'b1));
        check({tag, " sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        iResetn          = 1'b0;
        st_request_n     = 1'b1;
        st_address       = '0;
        st_data          = '0;
        st_size          = 1'b0;
        wb_accept_n      = 1'b1;
        rd_check_address = '0;
        start_shutdown   = 1'b0;

        // T1: reset values
        repeat (2) tick();
        check("rst req", 64'(wb_request_n), 64'(1'b1));
        check("rst addr", 64'(wb_address), 64'd0);
        check("rst data", 64'(wb_data), 64'd0);
        check("rst size", 64'(wb_size), 64'd0);
        check("rst stall", 64'(st_stall), 64'd0);
        check("rst empty", 64'(wb_empty), 64'(1'b1));
        check("rst hazard", 64'(rd_hazard), 64'd0);
        check("rst fin", 64'(finished_shutdown), 64'd0);
        iResetn = 1'b1;
        tick();

        // T1: reset in the middle of a request with three entries queued
        store(32'h0000_0010, 32'h1111_1111, 1'b0, 1'b0);
        store(32'h0000_0020, 32'h2222_2222, 1'b0, 1'b0);
        store(32'h0000_0030, 32'h3333_3333, 1'b1, 1'b0);
        check("t1 req_before", 64'(wb_request_n), 64'd0);
        check("t1 empty_before", 64'(wb_empty), 64'd0);
        iResetn = 1'b0;
        #1;
        check("t1 req_async", 64'(wb_request_n), 64'(1'b1));
        check("t1 empty_async", 64'(wb_empty), 64'(1'b1));
        iResetn = 1'b1;
        tick();
        expect_idle("t1");

        // T2: single store, one-clock latency, then gap
        store(32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("t2 req_not_yet", 64'(wb_request_n), 64'(1'b1));
        tick();
        check("t2 req_latency", 64'(wb_request_n), 64'd0);
        accept_head("t2", 1'b0, '0, '0, 1'b0, 1'b0);
        check("t2 empty", 64'(wb_empty), 64'(1'b1));
        check("t2 gap1", 64'(wb_request_n), 64'(1'b1));
        tick();
        check("t2 gap2", 64'(wb_request_n), 64'(1'b1));

        // T3: fill to full, fifth store dropped, in-order drain
        for (int i = 0; i < 4; i++) begin
            store(32'h0000_2000 + 32'(i) * 32'h100, 32'h0000_00A0 + 32'(i), 1'(i), 1'b1);
        end
        check("t3 stall_full", 64'(st_stall), 64'(1'b1));
        check("t3 not_empty", 64'(wb_empty), 64'd0);
        store(32'h0000_2400, 32'h0000_00A4, 1'b0, 1'b0);
        check("t3 stall_still", 64'(st_stall), 64'(1'b1));
        accept_head("t3 e0", 1'b0, '0, '0, 1'b0, 1'b0);
        check("t3 stall_released", 64'(st_stall), 64'd0);
        for (int i = 1; i < 4; i++) begin
            accept_head("t3 en", 1'b0, '0, '0, 1'b0, 1'b0);
        end
        expect_idle("t3");

        // T4: line hazard
        rd_check_address = 32'h1234_5670;
        st_request_n     = 1'b0;
        st_address       = 32'h1234_5678;
        st_data          = 32'h5555_AAAA;
        st_size          = 1'b0;
        sb.push_back('{a: 32'h1234_5678, d: 32'h5555_AAAA, s: 1'b0});
        #1;
        check("t4 hz_same_cycle", 64'(rd_hazard), 64'd0);
        tick();
        st_request_n = 1'b1;
        check("t4 hz_same_line", 64'(rd_hazard), 64'(1'b1));
        rd_check_address = 32'h1234_5680;
        #1;
        check("t4 hz_next_line", 64'(rd_hazard), 64'd0);
        rd_check_address = 32'h1234_5670;
        #1;
        check("t4 hz_back", 64'(rd_hazard), 64'(1'b1));
        tick();
        check("t4 in_req", 64'(wb_request_n), 64'd0);
        check("t4 hz_in_req", 64'(rd_hazard), 64'(1'b1));
        accept_head("t4", 1'b0, '0, '0, 1'b0, 1'b0);
        check("t4 hz_after_pop", 64'(rd_hazard), 64'd0);
        repeat (3) tick();

        // T5: shutdown with three queued; same-cycle store still accepted
        store(32'h0000_3000, 32'h0000_C000, 1'b0, 1'b1);
        store(32'h0000_3010, 32'h0000_C001, 1'b1, 1'b1);
        start_shutdown = 1'b1;
        store(32'h0000_3020, 32'h0000_C002, 1'b0, 1'b1);
        start_shutdown = 1'b0;
        check("t5 stall", 64'(st_stall), 64'(1'b1));
        store(32'h0000_3030, 32'h0000_C003, 1'b0, 1'b0);
        start_shutdown = 1'b1;
        tick();
        start_shutdown = 1'b0;
        for (int i = 0; i < 3; i++) begin
            accept_head("t5", 1'b0, '0, '0, 1'b0, 1'b0);
        end
        check("t5 fin_not_yet", 64'(finished_shutdown), 64'd0);
        check("t5 empty", 64'(wb_empty), 64'(1'b1));
        repeat (3) tick();
        check("t5 fin", 64'(finished_shutdown), 64'(1'b1));
        store(32'h0000_3040, 32'h0000_C004, 1'b0, 1'b0);
        expect_idle("t5");
        check("t5 fin_sticky", 64'(finished_shutdown), 64'(1'b1));
        check("t5 stall_sticky", 64'(st_stall), 64'(1'b1));

        // T6: clear shutdown via reset
        iResetn = 1'b0;
        #1;
        check("t6 rst_fin", 64'(finished_shutdown), 64'd0);
        check("t6 rst_stall", 64'(st_stall), 64'd0);
        iResetn = 1'b1;
        tick();

        // T6: store and pop together at count 2
        store(32'h0000_4000, 32'h0000_00B0, 1'b0, 1'b1);
        store(32'h0000_4010, 32'h0000_00B1, 1'b1, 1'b1);
        accept_head("t6 pop_st", 1'b1, 32'h0000_4020, 32'h0000_00B2, 1'b0, 1'b1);
        check("t6 stall_cnt2", 64'(st_stall), 64'd0);
        check("t6 not_empty", 64'(wb_empty), 64'd0);
        store(32'h0000_4030, 32'h0000_00B3, 1'b0, 1'b1);
        store(32'h0000_4040, 32'h0000_00B4, 1'b1, 1'b1);
        check("t6 stall_full", 64'(st_stall), 64'(1'b1));

        // T6: store while full with a pop in the same cycle is dropped
        accept_head("t6 full_pop", 1'b1, 32'h0000_4050, 32'h0000_00B5, 1'b0, 1'b0);
        check("t6 stall_after_pop", 64'(st_stall), 64'd0);
        for (int i = 0; i < 3; i++) begin
            accept_head("t6 drain", 1'b0, '0, '0, 1'b0, 1'b0);
        end
        expect_idle("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
